// File: rtl/spi_reg_bank_ctrl_pkg.sv
// Shared definitions for the SPI register bank controller: fast command codes,
// status byte layout and the controller state encoding.
package spi_reg_pkg;

  localparam logic [5:0] FC_NOP        = 6'h00;
  localparam logic [5:0] FC_SOFT_CLR   = 6'h01;
  localparam logic [5:0] FC_CLR_STICKY = 6'h02;
  localparam logic [5:0] FC_IRQ_CLR    = 6'h03;

  localparam int ST_BUSY     = 0;
  localparam int ST_IRQ      = 1;
  localparam int ST_WR_DROP  = 2;
  localparam int ST_BAD_CMD  = 3;
  localparam int ST_RO_WR    = 4;
  localparam int ST_CONF_LSB = 5;
  localparam int CONF_W      = 3;

  typedef enum logic [1:0] {
    IDLE,
    RD_RESP,
    CLEAR
  } bank_state_t;

endpackage

// File: rtl/spi_reg_bank_ctrl_if.sv
// Bus bundle between the register bank controller, the SPI slave and the core:
// SPI access, fast commands, core request/grant and the bank mirror.
interface spi_reg_bank_ctrl_if #(
  parameter int ADDR_W = 3,
  parameter int REG_W  = 8
);
  logic [ADDR_W-1:0]            spi_addr;
  logic [REG_W-1:0]             spi_rdata;
  logic [REG_W-1:0]             spi_wdata;
  logic                         spi_wvld;
  logic [5:0]                   fastcmd;
  logic                         fastcmd_vld;
  logic [7:0]                   status;
  logic                         core_req;
  logic                         core_we;
  logic [ADDR_W-1:0]            core_addr;
  logic [REG_W-1:0]             core_wdata;
  logic                         core_gnt;
  logic                         core_rvld;
  logic [REG_W-1:0]             core_rdata;
  logic                         irq;
  logic [(2**ADDR_W)*REG_W-1:0] regs_flat;

  modport master (
    output spi_addr, spi_wdata, spi_wvld, fastcmd, fastcmd_vld,
           core_req, core_we, core_addr, core_wdata,
    input  spi_rdata, status, core_gnt, core_rvld, core_rdata, irq, regs_flat
  );

  modport slave (
    input  spi_addr, spi_wdata, spi_wvld, fastcmd, fastcmd_vld,
           core_req, core_we, core_addr, core_wdata,
    output spi_rdata, status, core_gnt, core_rvld, core_rdata, irq, regs_flat
  );
endinterface

// File: rtl/spi_reg_bank_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear; an increment in the same
// cycle as a clear takes precedence.
module sat_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) begin
      if (cnt_q != '1) cnt_d = cnt_q + W'(1);
    end else if (clr_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/spi_reg_bank_ctrl.sv
// Register bank shared between the SPI slave and the core, with fast commands,
// a sequenced soft clear, the SPI status byte and a flat configuration mirror.
module spi_reg_bank_ctrl
  import spi_reg_pkg::*;
#(
  parameter int                    ADDR_W  = 3,
  parameter int                    REG_W   = 8,
  parameter logic [2**ADDR_W-1:0] RO_MASK = '0
) (
  input logic               clk,
  input logic               nrst,
  spi_reg_bank_ctrl_if.slave bus
);

  localparam int DEPTH = 2**ADDR_W;

  logic [REG_W-1:0]  bank_q [DEPTH];
  bank_state_t       state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic              irq_q, irq_d;
  logic              ro_wr_q, ro_wr_d;
  logic              wr_drop_q, wr_drop_d;
  logic              bad_cmd_q, bad_cmd_d;
  logic [REG_W-1:0]  core_rdata_q, core_rdata_d;
  logic [CONF_W-1:0] conf_cnt;

  logic              cmd_soft_clr, cmd_clr_sticky, cmd_irq_clr, cmd_bad;
  logic              in_clear, spi_ro, spi_wr_ok, core_gnt, conflict;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [REG_W-1:0]  wdata;

  always_comb begin
    cmd_soft_clr   = bus.fastcmd_vld && (bus.fastcmd == FC_SOFT_CLR);
    cmd_clr_sticky = bus.fastcmd_vld && (bus.fastcmd == FC_CLR_STICKY);
    cmd_irq_clr    = bus.fastcmd_vld && (bus.fastcmd == FC_IRQ_CLR);
    cmd_bad        = bus.fastcmd_vld && !(bus.fastcmd inside
                     {FC_NOP, FC_SOFT_CLR, FC_CLR_STICKY, FC_IRQ_CLR});

    in_clear  = (state_q == CLEAR);
    spi_ro    = RO_MASK[bus.spi_addr];
    spi_wr_ok = bus.spi_wvld && !in_clear && !spi_ro;
    // SPI writes cannot be stalled, so the core only gets the slot when SPI is quiet
    core_gnt  = (state_q == IDLE) && bus.core_req && !bus.spi_wvld && !cmd_soft_clr;
    conflict  = (state_q == IDLE) && bus.core_req && bus.spi_wvld;

    we    = 1'b0;
    waddr = bus.spi_addr;
    wdata = bus.spi_wdata;
    if (in_clear) begin
      we    = !RO_MASK[clr_idx_q];
      waddr = clr_idx_q;
      wdata = '0;
    end else if (spi_wr_ok) begin
      we = 1'b1;
    end else if (core_gnt && bus.core_we) begin
      we    = 1'b1;
      waddr = bus.core_addr;
      wdata = bus.core_wdata;
    end

    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      IDLE: begin
        if (cmd_soft_clr) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end else if (core_gnt && !bus.core_we) begin
          state_d = RD_RESP;
        end
      end
      RD_RESP: begin
        state_d   = cmd_soft_clr ? CLEAR : IDLE;
        clr_idx_d = '0;
      end
      CLEAR: begin
        if (clr_idx_q == ADDR_W'(DEPTH - 1)) state_d = IDLE;
        else                                 clr_idx_d = clr_idx_q + ADDR_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // set terms are OR-ed last so a same-cycle set beats the clear
    irq_d     = spi_wr_ok || (irq_q && !cmd_irq_clr);
    ro_wr_d   = (bus.spi_wvld && !in_clear && spi_ro) || (ro_wr_q && !cmd_clr_sticky);
    wr_drop_d = (bus.spi_wvld && in_clear) || (wr_drop_q && !cmd_clr_sticky);
    bad_cmd_d = cmd_bad || (bad_cmd_q && !cmd_clr_sticky);

    core_rdata_d = (core_gnt && !bus.core_we) ? bank_q[bus.core_addr] : core_rdata_q;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      clr_idx_q    <= '0;
      irq_q        <= 1'b0;
      ro_wr_q      <= 1'b0;
      wr_drop_q    <= 1'b0;
      bad_cmd_q    <= 1'b0;
      core_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      irq_q        <= irq_d;
      ro_wr_q      <= ro_wr_d;
      wr_drop_q    <= wr_drop_d;
      bad_cmd_q    <= bad_cmd_d;
      core_rdata_q <= core_rdata_d;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
    end else if (we) begin
      bank_q[waddr] <= wdata;
    end
  end

  sat_cnt #(.W(CONF_W)) u_conf_cnt (
    .clk   (clk),
    .nrst  (nrst),
    .inc_i (conflict),
    .clr_i (cmd_clr_sticky),
    .cnt_o (conf_cnt)
  );

  always_comb begin
    bus.status                          = '0;
    bus.status[ST_BUSY]                 = in_clear;
    bus.status[ST_IRQ]                  = irq_q;
    bus.status[ST_WR_DROP]              = wr_drop_q;
    bus.status[ST_BAD_CMD]              = bad_cmd_q;
    bus.status[ST_RO_WR]                = ro_wr_q;
    bus.status[ST_CONF_LSB +: CONF_W]   = conf_cnt;
  end

  always_comb begin
    bus.regs_flat = '0;
    for (int i = 0; i < DEPTH; i++) bus.regs_flat[i*REG_W +: REG_W] = bank_q[i];
  end

  assign bus.spi_rdata  = bank_q[bus.spi_addr];
  assign bus.core_gnt   = core_gnt;
  assign bus.core_rvld  = (state_q == RD_RESP);
  assign bus.core_rdata = core_rdata_q;
  assign bus.irq        = irq_q;

endmodule

// File: tb/tb_spi_reg_bank_ctrl.sv
// Directed bench for spi_reg_bank_ctrl with register 0 read-only from SPI.
module tb_spi_reg_bank_ctrl;

  logic clk;
  logic nrst;
  int   checks;
  int   failures;

  spi_reg_bank_ctrl_if #(.ADDR_W(3), .REG_W(8)) bus ();

  spi_reg_bank_ctrl #(
    .ADDR_W  (3),
    .REG_W   (8),
    .RO_MASK (8'h01)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    bus.spi_addr = '0; bus.spi_wdata = '0; bus.spi_wvld = 1'b0;
    bus.fastcmd = '0; bus.fastcmd_vld = 1'b0;
    bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_addr = '0; bus.core_wdata = '0;
    #12;
    checks++; if (bus.status !== 8'h00) begin failures++; $display("FAIL reset_status got=%h exp=00", bus.status); end
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", bus.irq); end
    checks++; if ({bus.core_gnt, bus.core_rvld} !== 2'b00) begin failures++; $display("FAIL reset_gnt_rvld got=%b exp=00", {bus.core_gnt, bus.core_rvld}); end
    checks++; if (bus.core_rdata !== 8'h00) begin failures++; $display("FAIL reset_core_rdata got=%h exp=00", bus.core_rdata); end
    checks++; if (bus.regs_flat !== 64'h0) begin failures++; $display("FAIL reset_regs_flat got=%h exp=0", bus.regs_flat); end
    nrst = 1'b1;
    cyc();
  endtask

  task automatic test_spi_write();
    bus.spi_addr = 3'd3; bus.spi_wdata = 8'hA5; bus.spi_wvld = 1'b1;
    cyc();
    bus.spi_wvld = 1'b0;
    #2;
    checks++; if (bus.spi_rdata !== 8'hA5) begin failures++; $display("FAIL spi_rdata_a3 got=%h exp=a5", bus.spi_rdata); end
    checks++; if (bus.irq !== 1'b1) begin failures++; $display("FAIL spi_write_irq got=%b exp=1", bus.irq); end
    checks++; if (bus.regs_flat[31:24] !== 8'hA5) begin failures++; $display("FAIL regs_flat_a3 got=%h exp=a5", bus.regs_flat[31:24]); end
    checks++; if (bus.status !== 8'h02) begin failures++; $display("FAIL status_after_write got=%h exp=02", bus.status); end
    bus.fastcmd = 6'h03; bus.fastcmd_vld = 1'b1;
    cyc();
    bus.fastcmd_vld = 1'b0;
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL irq_clr got=%b exp=0", bus.irq); end
  endtask

  task automatic test_core_read();
    bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 3'd3;
    #2;
    checks++; if (bus.core_gnt !== 1'b1) begin failures++; $display("FAIL core_rd_gnt got=%b exp=1", bus.core_gnt); end
    cyc();
    checks++; if (bus.core_rvld !== 1'b1) begin failures++; $display("FAIL core_rvld got=%b exp=1", bus.core_rvld); end
    checks++; if (bus.core_rdata !== 8'hA5) begin failures++; $display("FAIL core_rdata got=%h exp=a5", bus.core_rdata); end
    checks++; if (bus.core_gnt !== 1'b0) begin failures++; $display("FAIL no_gnt_in_rd_resp got=%b exp=0", bus.core_gnt); end
    bus.core_req = 1'b0;
    cyc();
    checks++; if (bus.core_rvld !== 1'b0) begin failures++; $display("FAIL rvld_one_cycle got=%b exp=0", bus.core_rvld); end
  endtask

  task automatic test_conflict();
    bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_addr = 3'd2; bus.core_wdata = 8'h3C;
    bus.spi_addr = 3'd5; bus.spi_wdata = 8'h55; bus.spi_wvld = 1'b1;
    #2;
    checks++; if (bus.core_gnt !== 1'b0) begin failures++; $display("FAIL conflict_no_gnt got=%b exp=0", bus.core_gnt); end
    cyc();
    bus.spi_wvld = 1'b0;
    #2;
    checks++; if (bus.status[7:5] !== 3'd1) begin failures++; $display("FAIL conflict_cnt1 got=%0d exp=1", bus.status[7:5]); end
    checks++; if (bus.core_gnt !== 1'b1) begin failures++; $display("FAIL conflict_retry_gnt got=%b exp=1", bus.core_gnt); end
    cyc();
    bus.core_req = 1'b0;
    bus.spi_addr = 3'd2;
    #1;
    checks++; if (bus.spi_rdata !== 8'h3C) begin failures++; $display("FAIL core_wr_a2 got=%h exp=3c", bus.spi_rdata); end
    checks++; if (bus.regs_flat[47:40] !== 8'h55) begin failures++; $display("FAIL spi_wr_a5 got=%h exp=55", bus.regs_flat[47:40]); end
    bus.core_req = 1'b1; bus.spi_addr = 3'd5; bus.spi_wvld = 1'b1;
    for (int i = 0; i < 8; i++) cyc();
    bus.core_req = 1'b0; bus.spi_wvld = 1'b0;
    checks++; if (bus.status[7:5] !== 3'd7) begin failures++; $display("FAIL conflict_sat got=%0d exp=7", bus.status[7:5]); end
    bus.fastcmd = 6'h02; bus.fastcmd_vld = 1'b1;
    cyc();
    bus.fastcmd = 6'h03;
    checks++; if (bus.status[7:5] !== 3'd0) begin failures++; $display("FAIL conflict_cleared got=%0d exp=0", bus.status[7:5]); end
    cyc();
    bus.fastcmd_vld = 1'b0;
  endtask

  task automatic test_set_wins();
    bus.spi_addr = 3'd1; bus.spi_wdata = 8'h42; bus.spi_wvld = 1'b1;
    bus.fastcmd = 6'h03; bus.fastcmd_vld = 1'b1;
    cyc();
    checks++; if (bus.irq !== 1'b1) begin failures++; $display("FAIL irq_set_wins got=%b exp=1", bus.irq); end
    bus.spi_addr = 3'd0; bus.fastcmd = 6'h02;
    cyc();
    bus.spi_wvld = 1'b0; bus.fastcmd = 6'h03;
    checks++; if (bus.status[4] !== 1'b1) begin failures++; $display("FAIL ro_wr_set_wins got=%b exp=1", bus.status[4]); end
    cyc();
    bus.fastcmd = 6'h02;
    cyc();
    bus.fastcmd_vld = 1'b0;
    checks++; if (bus.status !== 8'h00) begin failures++; $display("FAIL status_clean got=%h exp=00", bus.status); end
  endtask

  task automatic test_ro();
    bus.spi_addr = 3'd0; bus.spi_wdata = 8'hFF; bus.spi_wvld = 1'b1;
    cyc();
    bus.spi_wvld = 1'b0;
    checks++; if (bus.spi_rdata !== 8'h00) begin failures++; $display("FAIL ro_unchanged got=%h exp=00", bus.spi_rdata); end
    checks++; if (bus.status[4] !== 1'b1) begin failures++; $display("FAIL ro_wr_flag got=%b exp=1", bus.status[4]); end
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL ro_no_irq got=%b exp=0", bus.irq); end
    bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_addr = 3'd0; bus.core_wdata = 8'h11;
    #2;
    checks++; if (bus.core_gnt !== 1'b1) begin failures++; $display("FAIL ro_core_gnt got=%b exp=1", bus.core_gnt); end
    cyc();
    bus.core_req = 1'b0;
    checks++; if (bus.spi_rdata !== 8'h11) begin failures++; $display("FAIL ro_core_write got=%h exp=11", bus.spi_rdata); end
    bus.fastcmd = 6'h02; bus.fastcmd_vld = 1'b1;
    cyc();
    bus.fastcmd_vld = 1'b0;
    checks++; if (bus.status[4] !== 1'b0) begin failures++; $display("FAIL ro_wr_cleared got=%b exp=0", bus.status[4]); end
  endtask

  task automatic test_soft_clear();
    bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_wdata = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      bus.core_addr = 3'(i);
      cyc();
    end
    bus.core_req = 1'b0;
    checks++; if (bus.regs_flat !== {8{8'hFF}}) begin failures++; $display("FAIL preload got=%h exp=all ff", bus.regs_flat); end
    bus.fastcmd = 6'h01; bus.fastcmd_vld = 1'b1;
    cyc();
    bus.fastcmd_vld = 1'b0;
    bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_addr = 3'd6; bus.core_wdata = 8'h77;
    for (int k = 0; k < 8; k++) begin
      bus.spi_addr = 3'd4; bus.spi_wdata = 8'h99; bus.spi_wvld = (k == 2);
      #2;
      checks++; if ({bus.status[0], bus.core_gnt} !== 2'b10) begin failures++; $display("FAIL clear_busy_nognt k=%0d got=%b exp=10", k, {bus.status[0], bus.core_gnt}); end
      cyc();
      bus.spi_wvld = 1'b0;
    end
    #2;
    checks++; if (bus.status[0] !== 1'b0) begin failures++; $display("FAIL clear_done_busy got=%b exp=0", bus.status[0]); end
    checks++; if (bus.status[2] !== 1'b1) begin failures++; $display("FAIL wr_drop got=%b exp=1", bus.status[2]); end
    checks++; if (bus.regs_flat !== 64'h0000_0000_0000_00FF) begin failures++; $display("FAIL clear_result got=%h exp=00000000000000ff", bus.regs_flat); end
    checks++; if (bus.core_gnt !== 1'b1) begin failures++; $display("FAIL gnt_after_clear got=%b exp=1", bus.core_gnt); end
    cyc();
    bus.core_req = 1'b0;
    checks++; if (bus.regs_flat !== 64'h0077_0000_0000_00FF) begin failures++; $display("FAIL core_wr_after_clear got=%h exp=00770000000000ff", bus.regs_flat); end
  endtask

  task automatic test_bad_cmd_reset();
    bus.fastcmd = 6'h02; bus.fastcmd_vld = 1'b1;
    cyc();
    bus.fastcmd = 6'h2A;
    cyc();
    bus.fastcmd_vld = 1'b0;
    checks++; if (bus.status !== 8'h08) begin failures++; $display("FAIL bad_cmd got=%h exp=08", bus.status); end
    bus.spi_addr = 3'd3; bus.spi_wdata = 8'h5A; bus.spi_wvld = 1'b1;
    cyc();
    bus.spi_wvld = 1'b0;
    bus.fastcmd = 6'h01; bus.fastcmd_vld = 1'b1;
    cyc();
    bus.fastcmd_vld = 1'b0;
    cyc();
    cyc();
    checks++; if (bus.status !== 8'h0B) begin failures++; $display("FAIL pre_reset_status got=%h exp=0b", bus.status); end
    nrst = 1'b0;
    #2;
    checks++; if (bus.status !== 8'h00) begin failures++; $display("FAIL midclr_reset_status got=%h exp=00", bus.status); end
    checks++; if ({bus.irq, bus.core_gnt, bus.core_rvld} !== 3'b000) begin failures++; $display("FAIL midclr_reset_ctl got=%b exp=000", {bus.irq, bus.core_gnt, bus.core_rvld}); end
    checks++; if (bus.regs_flat !== 64'h0) begin failures++; $display("FAIL midclr_reset_bank got=%h exp=0", bus.regs_flat); end
    nrst = 1'b1;
    cyc();
    checks++; if (bus.status !== 8'h00) begin failures++; $display("FAIL post_reset_status got=%h exp=00", bus.status); end
    bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 3'd3;
    #2;
    checks++; if (bus.core_gnt !== 1'b1) begin failures++; $display("FAIL post_reset_idle_gnt got=%b exp=1", bus.core_gnt); end
    cyc();
    bus.core_req = 1'b0;
    checks++; if ({bus.core_rvld, bus.core_rdata} !== {1'b1, 8'h00}) begin failures++; $display("FAIL post_reset_read got=%b/%h exp=1/00", bus.core_rvld, bus.core_rdata); end
    cyc();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_spi_write();
    test_core_read();
    test_conflict();
    test_set_wins();
    test_ro();
    test_soft_clear();
    test_bad_cmd_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_reg_bank_ctrl.md
Name: spi_reg_bank_ctrl

Overview:
- Owns the register bank behind the SPI register slave and shares it between two requesters: the SPI slave's write strobe and an on-chip core requester.
- Serves SPI reads combinationally and executes the SPI fast commands, including a sequenced bank clear.
- Composes the 8-bit status byte returned to the SPI host.
- Mirrors the bank flat onto an output bus for configuration fan-out.

Parameters:
- ADDR_W, 3, register address width; bank depth is 2**ADDR_W.
- REG_W, 8, register width in bits; must be a multiple of 8.
- RO_MASK, {2**ADDR_W{1'b0}}, bit i set means register i is read-only from SPI. The core may still write it. Soft clear skips it.

Ports:
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- spi_addr  in  ADDR_W  SPI register address
- spi_rdata  out  REG_W  bank[spi_addr], combinational
- spi_wdata  in  REG_W  SPI write data
- spi_wvld  in  1  one-cycle SPI write strobe; cannot be stalled
- fastcmd  in  6  fast command code
- fastcmd_vld  in  1  one-cycle fast command strobe
- status  out  8  status byte to the SPI slave
- core_req  in  1  core access request; held until core_gnt
- core_we  in  1  1 = write, 0 = read
- core_addr  in  ADDR_W  core address
- core_wdata  in  REG_W  core write data
- core_gnt  out  1  one-cycle accept pulse
- core_rvld  out  1  one-cycle read-data-valid pulse
- core_rdata  out  REG_W  read data, valid only with core_rvld
- irq  out  1  level; set by any accepted SPI write
- regs_flat  out  (2**ADDR_W)*REG_W  bank mirror; register i at [i*REG_W +: REG_W]

Behaviour:
- Reset: every bank entry is 0. status, irq, core_gnt, core_rvld and core_rdata are 0. State is IDLE.
- States:
  - IDLE: grant decision each cycle.
  - RD_RESP: one cycle; core_rvld=1 and core_rdata = value latched at grant. No grant is issued here. Next state is IDLE.
  - CLEAR: clear counter clr_idx walks 0..2**ADDR_W-1, one entry per cycle. RW entries are written to 0; RO entries are untouched. After the last index the next state is IDLE.
- SPI write (spi_wvld=1):
  - In IDLE or RD_RESP: bank[spi_addr] <= spi_wdata, visible the next cycle, and irq <= 1.
  - If RO_MASK[spi_addr]=1: no write, irq is not set, and sticky RO_WR is set.
  - In CLEAR: the write is dropped and sticky WR_DROP is set.
- Core arbitration in IDLE:
  - The core is granted when core_req=1 and spi_wvld=0 and no SOFT_CLR is accepted in the same cycle.
  - Write: bank[core_addr] <= core_wdata in the grant cycle; the FSM stays in IDLE.
  - Read: core_rdata is latched and the FSM goes to RD_RESP, so core_rvld appears at grant+1.
  - If core_req=1 and spi_wvld=1: SPI wins, no core_gnt, and the 3-bit saturating conflict counter increments (7 holds).
  - The core retries automatically because core_req stays high.
- Fast commands (codes in the package):
  - 0x00 NOP: no effect.
  - 0x01 SOFT_CLR: accepted in IDLE or RD_RESP. If it arrives in RD_RESP, the pending rvld still completes and CLEAR starts the following cycle. Ignored while in CLEAR.
  - 0x02 CLR_STICKY: clears RO_WR, WR_DROP, BAD_CMD and the conflict counter.
  - 0x03 IRQ_CLR: irq <= 0.
  - Any other code: sticky BAD_CMD.
  - CLR_STICKY and IRQ_CLR act in every state.
- Simultaneous events:
  - A set and a clear of a sticky bit or irq in the same cycle: set wins.
  - SPI write to an address that a granted core write targets in the same cycle: cannot occur, because the core is not granted.
- status bit map:
  - [0] busy (state==CLEAR)
  - [1] irq
  - [2] WR_DROP
  - [3] BAD_CMD
  - [4] RO_WR
  - [7:5] conflict counter
- Width rule: the address and clr_idx counter are ADDR_W bits. The CLEAR terminal condition is clr_idx == 2**ADDR_W-1; there is no wrap past it.
- Reset mid-CLEAR or mid-RD_RESP: immediate return to the reset values. No core_rvld is emitted.

Decomposition:
- Package spi_reg_pkg holds:
  - fastcmd code localparams (FC_NOP, FC_SOFT_CLR, FC_CLR_STICKY, FC_IRQ_CLR);
  - status bit index localparams;
  - state enum typedef bank_state_t {IDLE, RD_RESP, CLEAR}.
- One natural sub-module: sat_cnt (parameterised width, inc and clr inputs, clr has priority over hold, inc wins over clr), used for the conflict counter.
- The bank storage and FSM stay inline.

Test Plan:
- SPI write 0xA5 to addr 3 -> spi_rdata with spi_addr=3 reads 0xA5 next cycle; irq=1; regs_flat[31:24]=0xA5; fastcmd 0x03 -> irq=0.
- Core read addr 3 after the write above -> core_gnt at cycle N, core_rvld=1 with core_rdata=0xA5 at N+1; no grant at N+1 even with core_req held.
- core_req write 0x3C to addr 2 with spi_wvld=1 in the same cycle -> no gnt that cycle, status[7:5]=1, gnt next cycle; after 8 more conflicts status[7:5]=7.
- RO_MASK=8'h01, SPI write 0xFF to addr 0 -> bank[0] unchanged, status[4]=1, irq stays 0; core write 0x11 to addr 0 -> accepted; fastcmd 0x02 -> status[4]=0.
- Bank preloaded with 0xFF in all entries, RO_MASK=8'h01, fastcmd 0x01 -> status[0]=1 for 8 cycles, then all RW entries are 0 and addr 0 stays 0xFF. An SPI write during the clear sets status[2]; core_req during the clear gets no gnt until busy drops.
- fastcmd 0x2A -> status[3]=1; assert nrst mid-CLEAR -> all outputs are 0 and state is IDLE.
